// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register/data widths, ALU opcodes,
// forwarding selects and the ID/EX register bundle.
package mips_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [3:0]           alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 4'b0010;
    localparam alu_ctrl_t ALU_SUB = 4'b0110;
    localparam alu_ctrl_t ALU_AND = 4'b0000;
    localparam alu_ctrl_t ALU_OR  = 4'b0001;
    localparam alu_ctrl_t ALU_SLT = 4'b0111;
    localparam alu_ctrl_t ALU_NOR = 4'b1100;
    localparam alu_ctrl_t ALU_MUL = 4'b0100;
    localparam alu_ctrl_t ALU_DIV = 4'b0101;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB
    } fwd_sel_e;

    typedef struct packed {
        logic      valid;
        alu_ctrl_t alu_control;
        word_t     op1;
        word_t     op2;
        word_t     store_data;
        reg_idx_t  rd;
        logic      reg_write;
        logic      mem_read;
    } ex_regs_t;

    // $0 is hard-wired, so it never participates in a dependency.
    function automatic logic reg_match(logic we, reg_idx_t rd, reg_idx_t src);
        return we && (rd == src) && (src != '0);
    endfunction

    function automatic word_t fwd_mux(fwd_sel_e sel, word_t rf, word_t ex,
                                      word_t mem, word_t wb);
        word_t v;
        case (sel)
            FWD_EX:  v = ex;
            FWD_MEM: v = mem;
            FWD_WB:  v = wb;
            default: v = rf;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode handshake, forwarding feedback from EX/MEM/WB,
// and the registered operands/control presented to the ALU.
interface id_ex_stage_if;
    import mips_pkg::*;

    logic      id_valid;
    logic      id_ready;
    alu_ctrl_t id_alu_control;
    reg_idx_t  id_rs;
    reg_idx_t  id_rt;
    reg_idx_t  id_rd;
    word_t     id_rs_data;
    word_t     id_rt_data;
    word_t     id_imm;
    logic      id_alu_src;
    logic      id_reg_write;
    logic      id_mem_read;
    logic      flush;

    word_t     alu_result;
    logic      exmem_reg_write;
    logic      exmem_mem_read;
    reg_idx_t  exmem_rd;
    word_t     exmem_result;
    logic      memwb_reg_write;
    reg_idx_t  memwb_rd;
    word_t     memwb_data;

    logic      ex_valid;
    alu_ctrl_t ex_alu_control;
    word_t     ex_op1;
    word_t     ex_op2;
    word_t     ex_store_data;
    reg_idx_t  ex_rd;
    logic      ex_reg_write;
    logic      ex_mem_read;
    logic [15:0] stall_cycles;

    modport master (
        output id_valid, id_alu_control, id_rs, id_rt, id_rd, id_rs_data,
               id_rt_data, id_imm, id_alu_src, id_reg_write, id_mem_read, flush,
               alu_result, exmem_reg_write, exmem_mem_read, exmem_rd,
               exmem_result, memwb_reg_write, memwb_rd, memwb_data,
        input  id_ready, ex_valid, ex_alu_control, ex_op1, ex_op2,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, stall_cycles
    );

    modport slave (
        input  id_valid, id_alu_control, id_rs, id_rt, id_rd, id_rs_data,
               id_rt_data, id_imm, id_alu_src, id_reg_write, id_mem_read, flush,
               alu_result, exmem_reg_write, exmem_mem_read, exmem_rd,
               exmem_result, memwb_reg_write, memwb_rd, memwb_data,
        output id_ready, ex_valid, ex_alu_control, ex_op1, ex_op2,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, stall_cycles
    );

endinterface

// File: rtl/id_ex_stage_hazard_fwd_unit.sv
// Combinational RAW hazard / forwarding unit. FORWARDING_EN enables bypass
// with load-use stalls; without it every dependency stalls until WB retires.
module hazard_fwd_unit
    import mips_pkg::*;
(
    input  logic     id_valid,
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    input  logic     id_alu_src,
    input  logic     id_mem_read,
    input  logic     flush,
    input  logic     ex_valid,
    input  logic     ex_reg_write,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  logic     exmem_reg_write,
    input  logic     exmem_mem_read,
    input  reg_idx_t exmem_rd,
    input  logic     memwb_reg_write,
    input  reg_idx_t memwb_rd,
    output fwd_sel_e rs_sel,
    output fwd_sel_e rt_sel,
    output logic     id_ready
);

    logic rs_ex, rs_mem, rs_wb;
    logic rt_ex, rt_mem, rt_wb;
    logic rt_active;
    logic load_use;
    logic hazard;

    assign rs_ex  = reg_match(ex_valid && ex_reg_write, ex_rd, id_rs);
    assign rs_mem = reg_match(exmem_reg_write, exmem_rd, id_rs);
    assign rs_wb  = reg_match(memwb_reg_write, memwb_rd, id_rs);
    assign rt_ex  = reg_match(ex_valid && ex_reg_write, ex_rd, id_rt);
    assign rt_mem = reg_match(exmem_reg_write, exmem_rd, id_rt);
    assign rt_wb  = reg_match(memwb_reg_write, memwb_rd, id_rt);

`ifdef FORWARDING_EN
    function automatic fwd_sel_e pick_src(logic ex_ok, logic mem_ok, logic wb_ok);
        if (ex_ok)       return FWD_EX;
        else if (mem_ok) return FWD_MEM;
        else if (wb_ok)  return FWD_WB;
        return FWD_RF;
    endfunction
`endif

    always_comb begin
        // rt is only a destination for loads (immediate op2, no store data)
        rt_active = !id_alu_src || !id_mem_read;
        load_use  = (rs_ex && ex_mem_read) || (rs_mem && exmem_mem_read) ||
                    (rt_active && ((rt_ex && ex_mem_read) || (rt_mem && exmem_mem_read)));
`ifdef FORWARDING_EN
        hazard = id_valid && load_use;
        rs_sel = pick_src(rs_ex && !ex_mem_read, rs_mem && !exmem_mem_read, rs_wb);
        rt_sel = pick_src(rt_ex && !ex_mem_read, rt_mem && !exmem_mem_read, rt_wb);
`else
        // load_use is a subset of the any-stage match; both terms kept for symmetry
        hazard = id_valid && (load_use || rs_ex || rs_mem || rs_wb ||
                              (rt_active && (rt_ex || rt_mem || rt_wb)));
        rs_sel = FWD_RF;
        rt_sel = FWD_RF;
`endif
        id_ready = flush || !hazard;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with forwarding, load-use stall,
// flush bubbles and a saturating stall counter. Build option: FORWARDING_EN.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    ex_regs_t    ex_q, ex_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    fwd_sel_e    rs_sel, rt_sel;
    logic        id_ready;
    word_t       rs_fwd, rt_fwd;

    hazard_fwd_unit u_hazard (
        .id_valid        (bus.id_valid),
        .id_rs           (bus.id_rs),
        .id_rt           (bus.id_rt),
        .id_alu_src      (bus.id_alu_src),
        .id_mem_read     (bus.id_mem_read),
        .flush           (bus.flush),
        .ex_valid        (ex_q.valid),
        .ex_reg_write    (ex_q.reg_write),
        .ex_mem_read     (ex_q.mem_read),
        .ex_rd           (ex_q.rd),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_mem_read  (bus.exmem_mem_read),
        .exmem_rd        (bus.exmem_rd),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .rs_sel          (rs_sel),
        .rt_sel          (rt_sel),
        .id_ready        (id_ready)
    );

    always_comb begin
        // Selects are tied to FWD_RF without forwarding, collapsing these muxes.
        rs_fwd = fwd_mux(rs_sel, bus.id_rs_data, bus.alu_result,
                         bus.exmem_result, bus.memwb_data);
        rt_fwd = fwd_mux(rt_sel, bus.id_rt_data, bus.alu_result,
                         bus.exmem_result, bus.memwb_data);

        ex_d = '0;
        if (bus.id_valid && id_ready && !bus.flush) begin
            ex_d.valid       = 1'b1;
            ex_d.alu_control = bus.id_alu_control;
            ex_d.op1         = rs_fwd;
            ex_d.op2         = bus.id_alu_src ? bus.id_imm : rt_fwd;
            ex_d.store_data  = rt_fwd;
            ex_d.rd          = bus.id_rd;
            ex_d.reg_write   = bus.id_reg_write;
            ex_d.mem_read    = bus.id_mem_read;
        end

        stall_cycles_d = stall_cycles_q;
        if (bus.id_valid && !id_ready && !bus.flush && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q           <= '0;
            stall_cycles_q <= '0;
        end else begin
            ex_q           <= ex_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.id_ready       = id_ready;
    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_alu_control = ex_q.alu_control;
    assign bus.ex_op1         = ex_q.op1;
    assign bus.ex_op2         = ex_q.op2;
    assign bus.ex_store_data  = ex_q.store_data;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.stall_cycles   = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a producer-list reference model. Honours FORWARDING_EN.
module tb_id_ex_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // model of what the EX register should hold
    logic        m_valid, m_rw, m_mr;
    logic [4:0]  m_rd;
    int unsigned m_stalls;

    typedef struct {
        bit          hit;
        bit          load;
        logic [31:0] val;
    } prod_t;

    // Producers ordered oldest (WB) to youngest (EX); the youngest hit supplies the value.
    function automatic void lookup(input logic [4:0] src, input logic [31:0] rf,
                                   output logic [31:0] val, output bit hazard);
        prod_t p[3];
        p[0] = '{bus.memwb_reg_write && bus.memwb_rd == src, 1'b0, bus.memwb_data};
        p[1] = '{bus.exmem_reg_write && bus.exmem_rd == src, bus.exmem_mem_read, bus.exmem_result};
        p[2] = '{m_valid && m_rw && m_rd == src, m_mr, bus.alu_result};
        val    = rf;
        hazard = 1'b0;
        if (src == 5'd0) return;
        for (int i = 0; i < 3; i++) begin
`ifdef FORWARDING_EN
            if (p[i].hit) val = p[i].val;
            if (p[i].hit && p[i].load) hazard = 1'b1;
`else
            if (p[i].hit) hazard = 1'b1;
`endif
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_alu_control = '0; bus.id_rs = '0; bus.id_rt = '0;
        bus.id_rd = '0; bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
        bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.flush = 0;
        bus.alu_result = '0; bus.exmem_reg_write = 0; bus.exmem_mem_read = 0;
        bus.exmem_rd = '0; bus.exmem_result = '0; bus.memwb_reg_write = 0;
        bus.memwb_rd = '0; bus.memwb_data = '0;
    endtask

    task automatic set_decode(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] rs_d, input logic [31:0] rt_d,
                              input logic [31:0] imm, input logic [3:0] alu,
                              input logic src, input logic rw, input logic mr);
        bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_imm = imm;
        bus.id_alu_control = alu; bus.id_alu_src = src;
        bus.id_reg_write = rw; bus.id_mem_read = mr;
    endtask

    task automatic set_exmem(input logic rw, input logic mr, input logic [4:0] rd,
                             input logic [31:0] res);
        bus.exmem_reg_write = rw; bus.exmem_mem_read = mr;
        bus.exmem_rd = rd; bus.exmem_result = res;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #3;
        n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_held: got %b want 0", bus.ex_valid); end
        apply_reset();
        n_cmp++;
        if ({bus.ex_valid, bus.ex_alu_control, bus.ex_op1, bus.ex_op2, bus.ex_store_data,
             bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read} !== 108'd0) begin
            n_bad++; $display("FAIL reset_ex_regs: got %h/%h/%h want all zero", bus.ex_op1, bus.ex_op2, bus.ex_rd);
        end
        n_cmp++; if (bus.stall_cycles !== 16'd0) begin n_bad++; $display("FAIL reset_stall: got %h want 0", bus.stall_cycles); end
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.id_ready); end
    endtask

    task automatic test_basic_add();
        apply_reset();
        set_decode(5'd3, 5'd4, 5'd10, 32'd5, 32'd7, 32'd0, 4'b0010, 0, 1, 0);
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if (bus.ex_op1 !== 32'd5) begin n_bad++; $display("FAIL add_op1: got %h want 5", bus.ex_op1); end
        n_cmp++; if (bus.ex_op2 !== 32'd7) begin n_bad++; $display("FAIL add_op2: got %h want 7", bus.ex_op2); end
        n_cmp++; if (bus.ex_alu_control !== 4'b0010) begin n_bad++; $display("FAIL add_alu: got %b want 0010", bus.ex_alu_control); end
        n_cmp++; if ({bus.ex_valid, bus.ex_rd, bus.ex_reg_write} !== {1'b1, 5'd10, 1'b1}) begin
            n_bad++; $display("FAIL add_ctrl: got %b/%0d/%b want 1/10/1", bus.ex_valid, bus.ex_rd, bus.ex_reg_write);
        end
        // immediate operand: op2 from imm, store data still rt
        set_decode(5'd3, 5'd4, 5'd11, 32'd5, 32'd7, 32'hFFFF_FFF0, 4'b0001, 1, 1, 0);
        step();
        n_cmp++; if ({bus.ex_op2, bus.ex_store_data} !== {32'hFFFF_FFF0, 32'd7}) begin
            n_bad++; $display("FAIL imm_op2: got %h/%h want fffffff0/7", bus.ex_op2, bus.ex_store_data);
        end
        bus.id_valid = 0;
        step();
        n_cmp++; if ({bus.ex_valid, bus.ex_op1, bus.ex_alu_control} !== 37'd0) begin
            n_bad++; $display("FAIL idle_bubble: got %b/%h want 0/0", bus.ex_valid, bus.ex_op1);
        end
    endtask

    task automatic test_ex_forward();
        apply_reset();
        set_decode(5'd1, 5'd2, 5'd8, 32'd1, 32'd2, 32'd0, 4'b0010, 0, 1, 0);
        step();
        set_decode(5'd8, 5'd2, 5'd11, 32'hDEAD, 32'd2, 32'd0, 4'b0010, 0, 1, 0);
        bus.alu_result = 32'h10;
        #1;
`ifdef FORWARDING_EN
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL exfwd_ready: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if (bus.ex_op1 !== 32'h10) begin n_bad++; $display("FAIL exfwd_op1: got %h want 10", bus.ex_op1); end
        n_cmp++; if (bus.stall_cycles !== 16'd0) begin n_bad++; $display("FAIL exfwd_stall: got %0d want 0", bus.stall_cycles); end
`else
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL nofwd_ex_ready: got %b want 0", bus.id_ready); end
        step();
        bus.alu_result = '0;
        set_exmem(1, 0, 5'd8, 32'h10);
        #1;
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL nofwd_mem_ready: got %b want 0", bus.id_ready); end
        step();
        set_exmem(0, 0, 5'd0, 32'd0);
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd8; bus.memwb_data = 32'h10;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL nofwd_wb_ready: got %b want 0", bus.id_ready); end
        step();
        bus.memwb_reg_write = 0; bus.id_rs_data = 32'h10;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL nofwd_release: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if (bus.ex_op1 !== 32'h10) begin n_bad++; $display("FAIL nofwd_op1: got %h want 10", bus.ex_op1); end
        n_cmp++; if (bus.stall_cycles !== 16'd3) begin n_bad++; $display("FAIL nofwd_stall: got %0d want 3", bus.stall_cycles); end
`endif
    endtask

    task automatic test_load_use();
        apply_reset();
        set_decode(5'd1, 5'd9, 5'd9, 32'h100, 32'd0, 32'd4, 4'b0010, 1, 1, 1);
        step();
        set_decode(5'd9, 5'd2, 5'd12, 32'hBAD, 32'd3, 32'd0, 4'b0010, 0, 1, 0);
        bus.alu_result = 32'h104;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready1: got %b want 0", bus.id_ready); end
        step();
        n_cmp++; if (bus.ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_bubble: got %b want 0", bus.ex_valid); end
        set_exmem(1, 1, 5'd9, 32'h104);
        #1;
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready2: got %b want 0", bus.id_ready); end
        step();
        set_exmem(0, 0, 5'd0, 32'd0);
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd9; bus.memwb_data = 32'h1234;
        #1;
`ifdef FORWARDING_EN
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL lu_ready3: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if (bus.stall_cycles !== 16'd2) begin n_bad++; $display("FAIL lu_stall: got %0d want 2", bus.stall_cycles); end
`else
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL lu_ready3: got %b want 0", bus.id_ready); end
        step();
        bus.memwb_reg_write = 0; bus.id_rs_data = 32'h1234;
        step();
        n_cmp++; if (bus.stall_cycles !== 16'd3) begin n_bad++; $display("FAIL lu_stall: got %0d want 3", bus.stall_cycles); end
`endif
        n_cmp++; if ({bus.ex_valid, bus.ex_op1} !== {1'b1, 32'h1234}) begin
            n_bad++; $display("FAIL lu_op1: got %b/%h want 1/1234", bus.ex_valid, bus.ex_op1);
        end
    endtask

    task automatic test_mem_wb_priority();
        apply_reset();
        set_exmem(1, 0, 5'd5, 32'd1);
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd5; bus.memwb_data = 32'd2;
        set_decode(5'd5, 5'd6, 5'd13, 32'h99, 32'h66, 32'd0, 4'b0110, 0, 1, 0);
        #1;
`ifdef FORWARDING_EN
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL prio_ready: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if (bus.ex_op1 !== 32'd1) begin n_bad++; $display("FAIL prio_op1: got %h want 1", bus.ex_op1); end
        set_exmem(0, 0, 5'd0, 32'd0);
        set_decode(5'd6, 5'd5, 5'd13, 32'h99, 32'h66, 32'd0, 4'b0110, 0, 1, 0);
        step();
        n_cmp++; if ({bus.ex_op2, bus.ex_store_data} !== {32'd2, 32'd2}) begin
            n_bad++; $display("FAIL wb_rt: got %h/%h want 2/2", bus.ex_op2, bus.ex_store_data);
        end
`else
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL prio_ready: got %b want 0", bus.id_ready); end
        step();
        n_cmp++; if ({bus.ex_valid, bus.stall_cycles} !== {1'b0, 16'd1}) begin
            n_bad++; $display("FAIL prio_stall: got %b/%0d want 0/1", bus.ex_valid, bus.stall_cycles);
        end
`endif
    endtask

    task automatic test_flush();
        apply_reset();
        set_decode(5'd1, 5'd9, 5'd9, 32'h100, 32'd0, 32'd4, 4'b0010, 1, 1, 1);
        step();
        set_decode(5'd9, 5'd2, 5'd12, 32'hBAD, 32'd3, 32'd0, 4'b0010, 0, 1, 0);
        step();
        set_exmem(1, 1, 5'd9, 32'h104);
        bus.flush = 1;
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_rd} !== 7'd0) begin
            n_bad++; $display("FAIL flush_bubble: got %b/%b/%0d want 0/0/0", bus.ex_valid, bus.ex_reg_write, bus.ex_rd);
        end
        n_cmp++; if (bus.stall_cycles !== 16'd1) begin n_bad++; $display("FAIL flush_stall: got %0d want 1", bus.stall_cycles); end
        bus.flush = 0;
    endtask

    task automatic test_r0();
        apply_reset();
        set_decode(5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 32'd0, 4'b0010, 0, 1, 0);
        step();
        bus.alu_result = 32'h77;
        set_exmem(1, 1, 5'd0, 32'h55);
        bus.memwb_reg_write = 1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'h66;
        set_decode(5'd0, 5'd0, 5'd14, 32'd0, 32'd0, 32'd0, 4'b0111, 0, 1, 0);
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL r0_ready: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if ({bus.ex_valid, bus.ex_op1, bus.ex_op2} !== {1'b1, 64'd0}) begin
            n_bad++; $display("FAIL r0_ops: got %b/%h/%h want 1/0/0", bus.ex_valid, bus.ex_op1, bus.ex_op2);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        set_exmem(1, 1, 5'd9, 32'h0);
        set_decode(5'd9, 5'd2, 5'd12, 32'hAB, 32'd3, 32'd0, 4'b0010, 0, 1, 0);
        step();
        step();
        set_exmem(0, 0, 5'd0, 32'd0);
        set_decode(5'd1, 5'd2, 5'd20, 32'd1, 32'd2, 32'd0, 4'b0010, 0, 1, 0);
        step();
        set_exmem(1, 1, 5'd9, 32'h0);
        set_decode(5'd9, 5'd2, 5'd12, 32'hAB, 32'd3, 32'd0, 4'b0010, 0, 1, 0);
        #1;
        n_cmp++; if ({bus.ex_valid, bus.stall_cycles} !== {1'b1, 16'd2}) begin
            n_bad++; $display("FAIL midrst_pre: got %b/%0d want 1/2", bus.ex_valid, bus.stall_cycles);
        end
        rst_n = 0;
        #1;
        n_cmp++; if ({bus.ex_valid, bus.ex_rd, bus.stall_cycles} !== 22'd0) begin
            n_bad++; $display("FAIL midrst_clear: got %b/%0d/%0d want 0/0/0", bus.ex_valid, bus.ex_rd, bus.stall_cycles);
        end
        rst_n = 1;
        set_exmem(0, 0, 5'd0, 32'd0);
        #1;
        n_cmp++; if (bus.id_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", bus.id_ready); end
        step();
        n_cmp++; if ({bus.ex_valid, bus.ex_op1, bus.stall_cycles} !== {1'b1, 32'hAB, 16'd0}) begin
            n_bad++; $display("FAIL midrst_retry: got %b/%h/%0d want 1/ab/0", bus.ex_valid, bus.ex_op1, bus.stall_cycles);
        end
    endtask

    task automatic test_random();
        logic [107:0] exp_vec, got_vec;
        logic [31:0]  v_rs, v_rt;
        bit           h_rs, h_rt, rt_act, ready_e;
        apply_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_rd = '0; m_stalls = 0;
        for (int unsigned c = 0; c < 400; c++) begin
            bus.id_valid       = ($urandom_range(0, 9) < 8);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.id_alu_control = 4'($urandom);
            bus.id_rs          = 5'($urandom_range(0, 3));
            bus.id_rt          = 5'($urandom_range(0, 3));
            bus.id_rd          = 5'($urandom_range(0, 3));
            bus.id_rs_data     = $urandom;
            bus.id_rt_data     = $urandom;
            bus.id_imm         = $urandom;
            bus.id_alu_src     = 1'($urandom);
            bus.id_reg_write   = 1'($urandom);
            bus.id_mem_read    = 1'($urandom);
            bus.alu_result     = $urandom;
            set_exmem(1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            bus.memwb_reg_write = 1'($urandom);
            bus.memwb_rd        = 5'($urandom_range(0, 3));
            bus.memwb_data      = $urandom;
            #1;
            lookup(bus.id_rs, bus.id_rs_data, v_rs, h_rs);
            lookup(bus.id_rt, bus.id_rt_data, v_rt, h_rt);
            rt_act  = !bus.id_alu_src || !bus.id_mem_read;
            ready_e = bus.flush || !(bus.id_valid && (h_rs || (rt_act && h_rt)));
            n_cmp++;
            if (bus.id_ready !== ready_e) begin
                n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, bus.id_ready, ready_e);
            end
            if (bus.id_valid && ready_e && !bus.flush)
                exp_vec = {1'b1, bus.id_alu_control, v_rs, bus.id_alu_src ? bus.id_imm : v_rt,
                           v_rt, bus.id_rd, bus.id_reg_write, bus.id_mem_read};
            else
                exp_vec = '0;
            if (bus.id_valid && !ready_e && !bus.flush && m_stalls < 65535) m_stalls++;
            step();
            m_valid = exp_vec[107]; m_rd = exp_vec[6:2]; m_rw = exp_vec[1]; m_mr = exp_vec[0];
            got_vec = {bus.ex_valid, bus.ex_alu_control, bus.ex_op1, bus.ex_op2, bus.ex_store_data,
                       bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read};
            n_cmp++;
            if (got_vec !== exp_vec) begin
                n_bad++; $display("FAIL rand_ex[%0d]: got %h want %h", c, got_vec, exp_vec);
            end
            n_cmp++;
            if (bus.stall_cycles !== 16'(m_stalls)) begin
                n_bad++; $display("FAIL rand_stall[%0d]: got %0d want %0d", c, bus.stall_cycles, m_stalls);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        set_exmem(1, 1, 5'd5, 32'd0);
        set_decode(5'd5, 5'd6, 5'd7, 32'd0, 32'd0, 32'd0, 4'b0010, 0, 1, 0);
        repeat (65534) @(posedge clk);
        #1;
        n_cmp++; if (bus.stall_cycles !== 16'hFFFE) begin n_bad++; $display("FAIL sat_fffe: got %h want fffe", bus.stall_cycles); end
        step();
        n_cmp++; if (bus.stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_ffff: got %h want ffff", bus.stall_cycles); end
        step();
        n_cmp++; if (bus.stall_cycles !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", bus.stall_cycles); end
        n_cmp++; if (bus.id_ready !== 1'b0) begin n_bad++; $display("FAIL sat_ready: got %b want 0", bus.id_ready); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_add();
        test_ex_forward();
        test_load_use();
        test_mem_wb_priority();
        test_flush();
        test_r0();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU: registers decoded operands and control, resolves RAW hazards by forwarding from the EX, MEM and WB stages, and drives the ALU's control and operand inputs. It detects load-use hazards, back-pressures decode with a one-signal ready, inserts bubbles, honours branch flush, and keeps a saturating stall-cycle counter.

## Interface
- No parameters; widths fixed at 32-bit data and 5-bit register index.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage accepts this cycle; low stalls IF/ID.
- id_alu_control  in  4  ALU operation code.
- id_rs, id_rt, id_rd  in  5 each  source and destination register numbers.
- id_rs_data, id_rt_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_alu_src  in  1  1 selects id_imm as op2.
- id_reg_write, id_mem_read  in  1 each  writes rd / is a load.
- flush  in  1  squash the decode instruction (taken branch).
- alu_result  in  32  current ALU output for the instruction held in EX.
- exmem_reg_write, exmem_mem_read  in  1 each; exmem_rd in 5; exmem_result in 32.
- memwb_reg_write  in  1; memwb_rd in 5; memwb_data in 32 (final write-back value).
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_control  out  4; ex_op1, ex_op2, ex_store_data  out  32 each.
- ex_rd  out  5; ex_reg_write, ex_mem_read  out  1 each.
- stall_cycles  out  16  saturating stall counter.

## Operation
- Transfer: rising edge with id_valid && id_ready && !flush captures the instruction into the EX registers, with ex_valid=1.
- Bubble: flush, id_valid=0, or id_valid && !id_ready loads ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd=0, ex_alu_control=4'b0000, and zero data.
- Match(src, stage): stage write enable=1 && stage rd==src && src!=0. EX match additionally requires ex_valid.
- Forward priority per source (rs, rt), highest first:
  - EX: alu_result, when the EX instruction is not a load.
  - MEM: exmem_result, when exmem_mem_read=0.
  - WB: memwb_data.
  - Otherwise: register-file data.
- Load-use stall: id_ready=0 when id_valid and rs, or rt with id_alu_src=0 or id_mem_read=0, matches a load in EX or a load in MEM. A load in EX therefore costs 2 stall cycles; a load in MEM costs 1.
- op1 = forwarded rs. op2 = id_imm if id_alu_src, else forwarded rt. ex_store_data = forwarded rt always.
- flush forces id_ready=1, so decode drops its instruction, and loads a bubble. flush beats stall.
- stall_cycles increments on each cycle with id_valid && !id_ready && !flush, and holds at 16'hFFFF.
- Register 0 never matches. Reading $0 always yields register-file data.

## Timing
- Reset: every ex_* output 0, ex_valid 0, stall_cycles 0. id_ready is combinational and reads 1 after reset.
- Latency: 1 cycle from accepted decode to ALU operands.
- id_ready is combinational from id_* and the stage match inputs, with no register in the path.
- Reset asserted mid-stall: all state clears immediately. After release the held decode instruction is re-evaluated against an empty pipeline.

## Configuration
- FORWARDING_EN defined: forwarding and load-use rules as above.
- FORWARDING_EN undefined:
  - No forwarding muxes; operands always come from the register file.
  - id_ready=0 whenever an active source matches EX, MEM or WB with any write enable.
  - A dependent instruction stalls until the producer leaves WB.
  - stall_cycles behaves identically.

## Structure
- Shared package `mips_pkg`:
  - ALU control constants: ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, SLT 4'b0111, NOR 4'b1100, MUL 4'b0100, DIV 4'b0101.
  - Forwarding-select enum: FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
  - Register-index width constant.
- One combinational sub-module `hazard_fwd_unit`: match logic, forwarding selects, id_ready. The top level holds the EX registers and counter.

## Test plan
- Reset, then `add` with rs=3 (data 5) and rt=4 (data 7) -> next cycle ex_op1=5, ex_op2=7, ex_alu_control=4'b0010, ex_valid=1.
- EX add writing r8 with alu_result=0x10, then decode reads r8 -> ex_op1=0x10 with no stall. Repeat with FORWARDING_EN undefined -> 3 stall cycles, stall_cycles=3.
- Load r9 in EX, then decode reads r9 -> id_ready=0 for 2 cycles. memwb_data=0x1234 is then forwarded, and stall_cycles=2.
- MEM and WB both write r5 (exmem_result=1, memwb_data=2), decode reads r5 -> ex_op1=1, the MEM value.
- flush during a load-use stall -> id_ready=1, bubble with ex_valid=0, stall_cycles unchanged.
- Decode reads r0 while EX writes r0 -> no forward, no stall. 65536 stall cycles -> stall_cycles=16'hFFFF.
